// File: rtl/adc_spi_sampler.sv
// Paces a 12-bit SPI ADC, converts offset-binary codes to signed 16-bit and
// forwards the first USED_PER_SEC samples of each second. Define ADC_DC_REMOVE_EN for DC removal.
module adc_spi_sampler #(
  parameter int CLK_FREQ_HZ     = 50000000,
  parameter int SAMPLE_RATE_HZ  = 25000,
  parameter int SCLK_DIV        = 4,
  parameter int SAMPLES_PER_SEC = 25000,
  parameter int USED_PER_SEC    = 24576
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  input  logic        adc_miso,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic [10:0] sample_index,
  output logic        overrun
);

  localparam int DIV = CLK_FREQ_HZ / SAMPLE_RATE_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int SW  = $clog2(SAMPLES_PER_SEC);
  localparam int HW  = $clog2(2 * SCLK_DIV);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] pace_cnt;
  logic [SW-1:0] sec_cnt;
  logic [HW-1:0] phase;
  logic [3:0]    bit_cnt;
  logic [11:0]   shift_reg;
  logic          tick;
  logic [15:0]   conv_x;
  logic [15:0]   conv_out;

  assign tick   = enable && (pace_cnt == '0);
  // Offset binary to two's complement is an MSB flip; the <<4 is the zero pad.
  assign conv_x = {~shift_reg[11], shift_reg[10:0], 4'h0};

`ifdef ADC_DC_REMOVE_EN
  logic signed [23:0] dc;
  logic signed [23:0] dc_next;
  logic signed [24:0] dc_diff;
  logic signed [24:0] dc_step;
  logic signed [16:0] dc_sub;

  always_comb begin
    dc_diff = {conv_x[15], conv_x, 8'h00} - {dc[23], dc};
    dc_step = dc_diff >>> 8;
    dc_next = dc + dc_step[23:0];
    dc_sub  = {conv_x[15], conv_x} - {dc[23], dc[23:8]};
    if (dc_sub[16] != dc_sub[15]) conv_out = dc_sub[16] ? 16'h8000 : 16'h7fff;
    else                          conv_out = dc_sub[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               dc <= '0;
    else if (state == DONE) dc <= dc_next;
  end
`else
  assign conv_out = conv_x;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         pace_cnt <= '0;
    else if (!enable)                 pace_cnt <= '0;
    else if (pace_cnt == PW'(DIV - 1)) pace_cnt <= '0;
    else                              pace_cnt <= pace_cnt + 1'b1;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      sample_index <= '0;
      overrun      <= 1'b0;
      sec_cnt      <= '0;
      phase        <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
    end else begin
      sample_valid <= 1'b0;
      if (sample_valid) sample_index <= sample_index + 1'b1;
      if (tick && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          adc_sclk <= 1'b0;
          if (!enable) begin
            sec_cnt      <= '0;
            sample_index <= '0;
          end else if (tick) begin
            state    <= SETUP;
            adc_cs_n <= 1'b0;
            phase    <= '0;
          end
        end
        SETUP: begin
          if (phase == HW'(SCLK_DIV - 1)) begin
            phase   <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        SHIFT: begin
          // miso is captured on the same edge that raises sclk
          if (phase == HW'(SCLK_DIV - 1)) begin
            adc_sclk  <= 1'b1;
            shift_reg <= {shift_reg[10:0], adc_miso};
            phase     <= phase + 1'b1;
          end else if (phase == HW'(2 * SCLK_DIV - 1)) begin
            adc_sclk <= 1'b0;
            phase    <= '0;
            if (bit_cnt == 4'd15) state   <= DONE;
            else                  bit_cnt <= bit_cnt + 1'b1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          adc_cs_n   <= 1'b1;
          adc_sclk   <= 1'b0;
          state      <= IDLE;
          sample_out <= conv_out;
          if (sec_cnt < SW'(USED_PER_SEC)) sample_valid <= 1'b1;
          if (sec_cnt == SW'(SAMPLES_PER_SEC - 1)) sec_cnt <= '0;
          else                                     sec_cnt <= sec_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Upstream acquisition stage for the overlapping-FFT write router.
- Paces conversions of an external 12-bit SPI ADC at 25 kS/s and converts each raw code to signed 16-bit.
- Emits a one-cycle sample_valid strobe with a 2048-cycle sample_index, which the router uses to select the FFT buffers.
- Only the first 24,576 samples of each 25,000-sample second are forwarded (24 FFT hops of 1024); the rest are discarded.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- SAMPLE_RATE_HZ, 25000, conversion rate; DIV = CLK_FREQ_HZ/SAMPLE_RATE_HZ = 2000 cycles.
- SCLK_DIV, 4, clk cycles per SCLK half-period (must be ≥2).
- SAMPLES_PER_SEC, 25000, length of the second counter.
- USED_PER_SEC, 24576, samples forwarded per second.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  acquisition enable.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  SPI clock, idle low.
- adc_miso  in  1  ADC serial data.
- sample_out  out  16  signed sample.
- sample_valid  out  1  one-cycle strobe; sample_out is valid in that cycle.
- sample_index  out  11  forwarded-sample counter, wraps 2047→0.
- overrun  out  1  sticky: a pace tick arrived while a transaction was still busy.

Behaviour:
- Reset (rst low, async): adc_cs_n=1, adc_sclk=0, sample_out=0, sample_valid=0, sample_index=0, overrun=0. Pace counter, second counter and FSM go to 0/IDLE.
- Pace counter: runs 0..DIV-1 while enable=1. Held at 0 while enable=0. A tick is any cycle with count==0 and enable=1, so the first tick is the first enabled cycle.
- FSM states: IDLE, SETUP, SHIFT, DONE.
  - IDLE → SETUP on tick; adc_cs_n←0.
  - SETUP holds SCLK_DIV cycles → SHIFT.
  - SHIFT runs 16 SCLK periods, each SCLK_DIV low then SCLK_DIV high, MSB first. adc_miso is sampled in the clk cycle where adc_sclk goes 0→1.
  - DONE: adc_cs_n←1, adc_sclk←0, conversion registered; next cycle → IDLE.
- ADC frame: bits 15..12 are leading zeros and are ignored; bits 11..0 are an unsigned offset-binary code raw.
- Conversion: sample_out = (raw − 2048) << 4, signed 16-bit. Examples: raw 0xFFF → 0x7FF0, raw 0x000 → 0x8000, raw 0x800 → 0x0000.
- Latency: sample_valid pulses exactly 16·2·SCLK_DIV + SCLK_DIV + 2 cycles after the tick cycle (134 with defaults). sample_out holds its value until the next valid.
- Second gating: sec_cnt increments on every completed conversion and wraps at SAMPLES_PER_SEC−1 → 0.
  - sample_valid asserts only when sec_cnt < USED_PER_SEC at completion.
  - sample_index increments after each asserted valid.
  - The dropped conversions (sec_cnt 24576..24999) produce no strobe and leave sample_index unchanged.
- Overrun: a tick arriving while the FSM is not IDLE is dropped and sets overrun. overrun clears only on reset.
- enable falling mid-transaction: the current transaction completes and its sample is emitted, subject to gating. Then the FSM returns to IDLE.
- enable low while in IDLE: sec_cnt and sample_index clear to 0, so the next enable starts a fresh second aligned to index 0.
- Reset mid-transaction: immediate return to reset values, adc_cs_n=1, and no partial sample is emitted.

Optional Feature:
- Macro: ADC_DC_REMOVE_EN.
- When defined:
  - A DC estimator dc (signed, 16 integer + 8 fractional bits, reset 0) updates on each completed conversion: dc ← dc + ((x − dc) >>> 8), where x is the converted sample.
  - sample_out = x − dc_int, saturated to [−32768, 32767], using dc_int from before the update.
  - The estimator updates on gated-out conversions too.
  - Latency is unchanged; the subtraction happens in DONE.
- When undefined: sample_out = x and no estimator logic is present.

Test Plan:
- Reset then enable=1, ADC model returns raw 0xFFF → sample_valid exactly 134 cycles after the first enabled cycle with sample_out=0x7FF0; adc_cs_n low for 133 cycles; exactly 16 adc_sclk rising edges.
- Raw sequence 0x000, 0x800, 0x801 → sample_out 0x8000, 0x0000, 0x0010; successive valids exactly 2000 cycles apart; sample_index 0, 1, 2.
- Run 25,000 conversions → 24,576 valids with sample_index wrapping 2047→0 twelve times; no valids during conversions 24576..24999; conversion 25000 gives valid with sample_index=0.
- Drop enable 50 cycles into SHIFT → transaction finishes and one valid is emitted; after idle, sec_cnt=0 and sample_index=0; re-enable gives index 0.
- Pulse rst low mid-SHIFT → outputs immediately at reset values, adc_cs_n=1, no valid; after release with enable=1 a fresh conversion starts on the first cycle.
- With ADC_DC_REMOVE_EN, constant raw 0xA00 → sample_out first 0x2000, decaying monotonically toward 0, below 0x0100 after 1000 conversions; without the macro it stays 0x2000.
